// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: grant states and source encodings shared by the round-robin mux arbiter
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} arb_state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: two requester legs in, one registered output bus out
interface mux_rr_arbiter_if #(parameter int WIDTH = 4);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_src;
  modport master (output req_a, req_b, data_a, data_b,
                  input grant_a, grant_b, sel, out_data, out_valid, out_src);
  modport slave (input req_a, req_b, data_a, data_b,
                 output grant_a, grant_b, sel, out_data, out_valid, out_src);
endinterface

// File: rtl/mux_rr_arbiter_mux2.sv
// mux2_w: WIDTH-bit 2-to-1 mux, s=0 picks x, s=1 picks y
module mux2_w #(parameter int WIDTH = 4) (
  input  logic             s,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] m
);
  assign m = s ? y : x;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant FSM with bounded hold sharing one 2-to-1 mux onto a registered output
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, mux_out;
  logic             out_valid_q, out_valid_d;
  logic             out_src_q, out_src_d;
  logic             sel, mine, other, beat;
  assign sel   = state_q == GNT_B;
  assign mine  = sel ? bus.req_b : bus.req_a;
  assign other = sel ? bus.req_a : bus.req_b;
  assign beat  = (state_q != IDLE) && mine;
  mux2_w #(.WIDTH(WIDTH)) u_mux (.s(sel), .x(bus.data_a), .y(bus.data_b), .m(mux_out));
  // last only changes when a granted side gives up the bus, so IDLE ties alternate
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (state_q == IDLE)
      state_d = (bus.req_a && bus.req_b) ? ((last_q == SRC_B) ? GNT_A : GNT_B) :
                bus.req_a ? GNT_A : bus.req_b ? GNT_B : IDLE;
    else if (!mine || (other && hold_q == HOLD_MAX))
      state_d = other ? (sel ? GNT_A : GNT_B) : IDLE;
    else
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    if (state_d != state_q) begin
      hold_d = '0;
      last_d = (state_q == IDLE) ? last_q : sel;
    end
    out_valid_d = beat;
    out_data_d  = beat ? mux_out : out_data_q;
    out_src_d   = beat ? sel : out_src_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= SRC_B;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= SRC_A;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  assign bus.grant_a   = state_q == GNT_A;
  assign bus.grant_b   = sel;
  assign bus.sel       = sel;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed literal checks plus randomized traffic against an ownership/streak model
module tb_mux_rr_arbiter;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // model: owner 0 = nobody, 1 = A, 2 = B; streak = cycles the current owner has held the bus
  int               m_own    = 0;
  bit               m_last_b = 1'b1;
  int               m_streak = 0;
  logic [WIDTH-1:0] m_data   = '0;
  bit               m_valid  = 1'b0;
  bit               m_src    = 1'b0;
  int               nxt;
  bit               ra, rb, mn, ot, bt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = 0; m_last_b = 1'b1; m_streak = 0; m_data = '0; m_valid = 1'b0; m_src = 1'b0;
    end else begin
      ra = bus.req_a;
      rb = bus.req_b;
      mn = (m_own == 1) ? ra : rb;
      ot = (m_own == 1) ? rb : ra;
      bt = (m_own != 0) && mn;
      m_valid = bt;
      if (bt) begin
        m_data = (m_own == 2) ? bus.data_b : bus.data_a;
        m_src  = (m_own == 2);
      end
      if (m_own == 0)
        nxt = (ra && rb) ? (m_last_b ? 1 : 2) : ra ? 1 : rb ? 2 : 0;
      else if (!mn)
        nxt = ot ? 3 - m_own : 0;
      else if (ot && m_streak >= MAX_HOLD)
        nxt = 3 - m_own;
      else
        nxt = m_own;
      if (m_own != 0 && nxt != m_own) m_last_b = (m_own == 2);
      m_streak = (nxt == 0) ? 0 : (nxt == m_own) ? m_streak + 1 : 1;
      m_own = nxt;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("grant_a", int'(bus.grant_a), int'(m_own == 1));
    chk("grant_b", int'(bus.grant_b), int'(m_own == 2));
    chk("sel", int'(bus.sel), int'(m_own == 2));
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("out_data", int'(bus.out_data), int'(m_data));
    chk("out_src", int'(bus.out_src), int'(m_src));
  end
  task automatic drive(input logic a, input logic b, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    bus.req_a  = a;
    bus.req_b  = b;
    bus.data_a = da;
    bus.data_b = db;
  endtask
  task automatic reset_to(input logic a, input logic b, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    #1 rst_n = 1'b0;
    drive(a, b, da, db);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  logic [11:0] pat;
  logic        a_r, b_r;
  initial begin
    drive(1'b1, 1'b1, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("t1_rst_grant_a", int'(bus.grant_a), 0);
    chk("t1_rst_grant_b", int'(bus.grant_b), 0);
    chk("t1_rst_valid", int'(bus.out_valid), 0);
    chk("t1_rst_data", int'(bus.out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_tie_a", int'(bus.grant_a), 1);
    chk("t1_first_tie_sel", int'(bus.sel), 0);
    reset_to(1'b1, 1'b0, 4'h5, 4'h0);
    @(negedge clk);
    chk("t2_grant_a", int'(bus.grant_a), 1);
    chk("t2_no_valid_yet", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("t2_out_data", int'(bus.out_data), 5);
    chk("t2_out_src", int'(bus.out_src), 0);
    chk("t2_out_valid", int'(bus.out_valid), 1);
    reset_to(1'b1, 1'b1, 4'h3, 4'h9);
    pat = 12'b000011110000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t3_rr_grant_b", int'(bus.grant_b), int'(pat[11-i]));
      chk("t3_rr_grant_a", int'(bus.grant_a), int'(!pat[11-i]));
    end
    reset_to(1'b1, 1'b1, 4'h7, 4'h0);
    @(negedge clk);
    chk("t4_grant_a", int'(bus.grant_a), 1);
    drive(1'b0, 1'b1, 4'h7, 4'hC);
    @(negedge clk);
    chk("t4_drop_no_valid", int'(bus.out_valid), 0);
    chk("t4_grant_b", int'(bus.grant_b), 1);
    @(negedge clk);
    chk("t4_data_c", int'(bus.out_data), 12);
    chk("t4_src_b", int'(bus.out_src), 1);
    chk("t4_valid", int'(bus.out_valid), 1);
    reset_to(1'b1, 1'b0, 4'h2, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h2, 4'h0);
    @(negedge clk);
    chk("t5_idle_a", int'(bus.grant_a), 0);
    chk("t5_idle_b", int'(bus.grant_b), 0);
    drive(1'b1, 1'b1, 4'h2, 4'h6);
    @(negedge clk);
    chk("t5_tie_after_a", int'(bus.grant_b), 1);
    @(negedge clk);
    chk("t6_pre_valid", int'(bus.out_valid), 1);
    chk("t6_pre_data", int'(bus.out_data), 6);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(bus.out_valid), 0);
    chk("t6_async_grant_b", int'(bus.grant_b), 0);
    chk("t6_async_data", int'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_a", int'(bus.grant_a), 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, WIDTH'(i), WIDTH'(15 - i));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, WIDTH'(15 - i), WIDTH'(i));
    end
    a_r = 1'b0;
    b_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(299) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      if ($urandom_range(3) == 0) a_r = ~a_r;
      if ($urandom_range(3) == 0) b_r = ~b_r;
      drive(a_r, b_r, WIDTH'($urandom), WIDTH'($urandom));
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
